// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage.
// Optional feature macro PWM_SOFT_START_EN is consumed by pwm_output_stage.
package pwm_pkg;

  localparam int PWM_WIDTH = 9;
  localparam int PWM_TOP   = 511;

  // Limits a requested high-time to one full period (top + 1 clocks).
  function automatic logic [31:0] clamp_sample(input logic [31:0] sample,
                                               input logic [31:0] top);
    logic [31:0] limit;
    limit = top + 32'd1;
    if (sample > limit) begin
      return limit;
    end else begin
      return sample;
    end
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running 0..TOP period counter with wrap flag and period-start decode.
module pwm_period_counter #(
  parameter int TOP = 511,
  parameter int CW  = (TOP > 0) ? $clog2(TOP + 1) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic [CW-1:0] o_count,
  output logic          o_wrap,
  output logic          o_period_start
);

  localparam logic [CW-1:0] LAST = CW'(TOP);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == LAST);

  // Period counter: counts 0..TOP and wraps back to zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= {CW{1'b0}};
    end else if (w_wrap) begin
      r_count <= {CW{1'b0}};
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count        = r_count;
  assign o_wrap         = w_wrap;
  assign o_period_start = (r_count == {CW{1'b0}});

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: pending/active compare registers, comparator, overrun flag.
// Optional feature: define PWM_SOFT_START_EN to limit compare changes to 1 per period.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int TOP   = PWM_TOP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic [WIDTH-1:0] o_compare,
  output logic             o_overrun
);

  localparam int          CW    = (TOP > 0) ? $clog2(TOP + 1) : 1;
  localparam logic [31:0] TOP_U = 32'(TOP);

  logic [CW-1:0]    w_count;
  logic             w_wrap;
  logic             w_period_start;
  logic [WIDTH-1:0] w_clamped;
  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_act_ext;
  logic             w_promote;
  logic             w_overrun_set;
  logic [WIDTH-1:0] w_active_next;
  logic [WIDTH-1:0] w_pending_next;
  logic             w_full_next;

  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_pending;
  logic             r_pending_full;
  logic             r_pwm;
  logic             r_overrun;

  pwm_period_counter #(.TOP(TOP), .CW(CW)) u_counter (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .o_count        (w_count),
    .o_wrap         (w_wrap),
    .o_period_start (w_period_start)
  );

  assign w_clamped     = WIDTH'(clamp_sample(32'(i_sample), TOP_U));
  assign w_cnt_ext     = (WIDTH + 1)'(w_count);
  assign w_act_ext     = {1'b0, r_active};
  assign w_promote     = w_wrap & r_pending_full;
  // A write colliding with a wrap refills the slot being promoted, so it is not lost.
  assign w_overrun_set = i_sample_valid & r_pending_full & ~w_wrap;

`ifdef PWM_SOFT_START_EN
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] w_target_next;

  // Active compare walks one step per wrap toward the most recent target.
  always_comb begin
    w_target_next = w_promote ? r_pending : r_target;
    w_active_next = r_active;
    if (w_wrap) begin
      if (r_active < w_target_next) begin
        w_active_next = r_active + WIDTH'(1);
      end else if (r_active > w_target_next) begin
        w_active_next = r_active - WIDTH'(1);
      end else begin
        w_active_next = r_active;
      end
    end else begin
      w_active_next = r_active;
    end
  end

  // Soft-start target register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_target <= {WIDTH{1'b0}};
    end else begin
      r_target <= w_target_next;
    end
  end
`else
  // Active compare jumps straight to the promoted value at a wrap.
  always_comb begin
    w_active_next = r_active;
    if (w_promote) begin
      w_active_next = r_pending;
    end else begin
      w_active_next = r_active;
    end
  end
`endif

  // Pending slot: a new sample always wins; promotion empties the slot otherwise.
  always_comb begin
    w_pending_next = r_pending;
    w_full_next    = r_pending_full;
    if (i_sample_valid) begin
      w_pending_next = w_clamped;
      w_full_next    = 1'b1;
    end else if (w_promote) begin
      w_pending_next = r_pending;
      w_full_next    = 1'b0;
    end else begin
      w_pending_next = r_pending;
      w_full_next    = r_pending_full;
    end
  end

  // State registers and registered PWM output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active       <= {WIDTH{1'b0}};
      r_pending      <= {WIDTH{1'b0}};
      r_pending_full <= 1'b0;
      r_pwm          <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_active       <= w_active_next;
      r_pending      <= w_pending_next;
      r_pending_full <= w_full_next;
      r_pwm          <= (w_cnt_ext < w_act_ext);
      r_overrun      <= r_overrun | w_overrun_set;
    end
  end

  assign o_pwm          = r_pwm;
  assign o_period_start = w_period_start;
  assign o_compare      = r_active;
  assign o_overrun      = r_overrun;

endmodule
